// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit sequencer:
//   - mdu_op_t      : MDU opcode carried by the E-stage instruction
//   - mdu_state_t   : sequencer state (IDLE / BUSY)
//   - MDU_CNT_W     : width of the busy countdown counter
//   - *_CYCLES_DEF  : default busy latencies for mult and div
//   - is_muldiv/is_div : opcode classification helpers
// -----------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    localparam int MDU_CNT_W        = 4;
    localparam int MULT_CYCLES_DEF  = 5;
    localparam int DIV_CYCLES_DEF   = 10;

    // Opcodes 9..15 fall through to "not an MDU compute op".
    function automatic logic is_muldiv(logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    function automatic logic is_div(logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// -----------------------------------------------------------------------------
// mdu_arith
// Combinational 64-bit result producer for mult/multu/div/divu.
// Ports:
//   op_i   [3:0]  MDU opcode
//   rs_i   [31:0] rs operand (multiplicand / dividend)
//   rt_i   [31:0] rt operand (multiplier / divisor)
//   hi_o   [31:0] upper product / remainder
//   lo_o   [31:0] lower product / quotient
//   keep_o        divide by zero: HI/LO must be left untouched at commit
// -----------------------------------------------------------------------------
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        keep_o
);

    logic [63:0] smul;
    logic [63:0] umul;
    logic        signed_div;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_b_safe;
    logic [31:0] quot;
    logic [31:0] rem;

    assign smul = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    assign umul = {32'd0, rs_i} * {32'd0, rt_i};

    // Signed division is done on magnitudes and the signs re-applied after.
    // This keeps 0x80000000 / -1 well defined: the magnitude quotient is
    // 0x80000000, which wraps back to 0x80000000 with a zero remainder.
    assign signed_div = (op_i == OP_DIV);
    assign rs_neg     = signed_div & rs_i[31];
    assign rt_neg     = signed_div & rt_i[31];
    assign div_a      = rs_neg ? (32'd0 - rs_i) : rs_i;
    assign div_b      = rt_neg ? (32'd0 - rt_i) : rt_i;
    // Never divide by zero in hardware; the result is discarded via keep_o.
    assign div_b_safe = (rt_i == 32'd0) ? 32'd1 : div_b;
    assign quot       = div_a / div_b_safe;
    assign rem        = div_a % div_b_safe;

    always_comb begin
        hi_o   = 32'd0;
        lo_o   = 32'd0;
        keep_o = 1'b0;
        case (mdu_op_t'(op_i))
            OP_MULT: begin
                hi_o = smul[63:32];
                lo_o = smul[31:0];
            end
            OP_MULTU: begin
                hi_o = umul[63:32];
                lo_o = umul[31:0];
            end
            OP_DIV, OP_DIVU: begin
                keep_o = (rt_i == 32'd0);
                lo_o   = (rs_neg ^ rt_neg) ? (32'd0 - quot) : quot;
                hi_o   = rs_neg ? (32'd0 - rem) : rem;
            end
            default: begin
                hi_o   = 32'd0;
                lo_o   = 32'd0;
                keep_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
// Sequencer for the MDU and the HI/LO registers of the 5-stage pipeline.
// A mult/div accepted in E computes its result into a shadow register, then
// a countdown models the unit latency; the shadow is committed to HI/LO on
// the last busy cycle. A D-stage MDU instruction is held via stall_req while
// the unit is starting or busy.
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   e_valid         E-stage instruction valid
//   e_op [3:0]      E-stage MDU opcode
//   e_rs, e_rt      forwarded operands
//   d_is_mdu        D-stage instruction is an MDU op
//   start           a mult/div is accepted this cycle
//   busy            MDU computing
//   hi, lo          architectural HI/LO
//   e_mdu_rd        mfhi/mflo read data
//   stall_req       freeze PC/F2D, bubble into D2E
//   perf_stall_cnt  stall cycle counter (only with MDU_PERF_CNT_EN defined)
// Build option: define MDU_PERF_CNT_EN to add perf_stall_cnt.
// -----------------------------------------------------------------------------
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_is_mdu,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] e_mdu_rd,
    output logic        stall_req
`ifdef MDU_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    mdu_state_t           state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          lo_q, lo_d;
    logic [31:0]          sh_hi_q, sh_hi_d;
    logic [31:0]          sh_lo_q, sh_lo_d;
    logic                 sh_keep_q, sh_keep_d;

    logic [31:0]          arith_hi;
    logic [31:0]          arith_lo;
    logic                 arith_keep;
    logic                 start_c;

    mdu_arith u_arith (
        .op_i   (e_op),
        .rs_i   (e_rs),
        .rt_i   (e_rt),
        .hi_o   (arith_hi),
        .lo_o   (arith_lo),
        .keep_o (arith_keep)
    );

    // Reset wins over a coinciding start, so the pulse is suppressed too.
    assign start_c = e_valid & is_muldiv(e_op) & (state_q == ST_IDLE) & ~reset;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        sh_hi_d   = sh_hi_q;
        sh_lo_d   = sh_lo_q;
        sh_keep_d = sh_keep_q;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    sh_hi_d   = arith_hi;
                    sh_lo_d   = arith_lo;
                    sh_keep_d = arith_keep;
                    cnt_d     = is_div(e_op) ? MDU_CNT_W'(DIV_CYCLES)
                                             : MDU_CNT_W'(MULT_CYCLES);
                    state_d   = ST_BUSY;
                end else if (e_valid && (e_op == OP_MTHI)) begin
                    hi_d = e_rs;
                end else if (e_valid && (e_op == OP_MTLO)) begin
                    lo_d = e_rs;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - MDU_CNT_W'(1);
                // Last busy cycle: result becomes visible as busy drops.
                if (cnt_q <= MDU_CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!sh_keep_q) begin
                        hi_d = sh_hi_q;
                        lo_d = sh_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            sh_hi_q   <= 32'd0;
            sh_lo_q   <= 32'd0;
            sh_keep_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            sh_hi_q   <= sh_hi_d;
            sh_lo_q   <= sh_lo_d;
            sh_keep_q <= sh_keep_d;
        end
    end

    assign start     = start_c;
    assign busy      = (state_q == ST_BUSY);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = d_is_mdu & (start_c | busy);

    always_comb begin
        e_mdu_rd = 32'd0;
        if (e_op == OP_MFHI) begin
            e_mdu_rd = hi_q;
        end else if (e_op == OP_MFLO) begin
            e_mdu_rd = lo_q;
        end
    end

`ifdef MDU_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= 32'd0;
        end else if (stall_req) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
// Self-checking bench for mdu_ctrl: directed scenarios followed by randomized
// MDU traffic, checked against a 64-bit arithmetic reference model.
// Build option: MDU_PERF_CNT_EN also checks perf_stall_cnt.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [3:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_is_mdu;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] e_mdu_rd;
    logic        stall_req;
`ifdef MDU_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          m_perf = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .e_valid   (e_valid),
        .e_op      (e_op),
        .e_rs      (e_rs),
        .e_rt      (e_rt),
        .d_is_mdu  (d_is_mdu),
        .start     (start),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .e_mdu_rd  (e_mdu_rd),
        .stall_req (stall_req)
`ifdef MDU_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference: new {HI,LO} after a mult/div commits, from plain 64-bit math.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [31:0] ohi,
                                          input logic [31:0] olo);
        longint          a, b, q, r;
        longint unsigned ua, ub, uq, ur;
        case (op)
            4'd1: begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                return 64'(a * b);
            end
            4'd2: begin
                ua = 64'(rs);
                ub = 64'(rt);
                return ua * ub;
            end
            4'd3: begin
                if (rt == 32'd0) return {ohi, olo};
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                q = a / b;
                r = a % b;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (rt == 32'd0) return {ohi, olo};
                ua = 64'(rs);
                ub = 64'(rt);
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic muldiv(input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic dm);
        int          n;
        logic [63:0] exp;
        n   = (op == 4'd3 || op == 4'd4) ? DC : MC;
        exp = model(op, rs, rt, m_hi, m_lo);
        e_valid = 1'b1; e_op = op; e_rs = rs; e_rt = rt; d_is_mdu = dm;
        #1;
        chk("start_pulse", 32'(start), 32'd1);
        chk("busy_at_start", 32'(busy), 32'd0);
        chk("stall_at_start", 32'(stall_req), 32'(dm));
        if (dm) m_perf++;
        next_cyc();
        e_valid = 1'b0; e_op = 4'd0;
        #1;
        for (int i = 0; i < n; i++) begin
            chk("busy_high", 32'(busy), 32'd1);
            chk("start_low_busy", 32'(start), 32'd0);
            chk("stall_busy", 32'(stall_req), 32'(dm));
            chk("hi_hold", hi, m_hi);
            if (dm) m_perf++;
            next_cyc();
        end
        d_is_mdu = 1'b0;
        {m_hi, m_lo} = exp;
        chk("busy_fall", 32'(busy), 32'd0);
        chk("hi_commit", hi, m_hi);
        chk("lo_commit", lo, m_lo);
        $display("op=%0d rs=%08h rt=%08h dm=%0d -> hi=%08h lo=%08h", op, rs, rt, dm, hi, lo);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] val);
        e_valid = 1'b1; e_op = op; e_rs = val; e_rt = 32'd0; d_is_mdu = 1'b0;
        #1;
        chk("mt_no_start", 32'(start), 32'd0);
        chk("mt_no_stall", 32'(stall_req), 32'd0);
        next_cyc();
        e_valid = 1'b0; e_op = 4'd0;
        if (op == 4'd5) m_hi = val; else m_lo = val;
        chk("mt_hi", hi, m_hi);
        chk("mt_lo", lo, m_lo);
        $display("op=%0d rs=%08h -> hi=%08h lo=%08h", op, val, hi, lo);
    endtask

    task automatic mf(input logic [3:0] op);
        e_valid = 1'b1; e_op = op;
        #1;
        chk("mf_rd", e_mdu_rd, (op == 4'd7) ? m_hi : m_lo);
        $display("op=%0d -> rd=%08h", op, e_mdu_rd);
        next_cyc();
        e_valid = 1'b0; e_op = 4'd0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; e_valid = 1'b0; e_op = 4'd0; e_rs = 32'd0; e_rt = 32'd0; d_is_mdu = 1'b1;
        next_cyc();
        next_cyc();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0; d_is_mdu = 1'b0;
        #1;

        // Directed scenarios
        muldiv(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        muldiv(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        muldiv(OP_DIVU, 32'd7, 32'd0, 1'b0);
        muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        mf(OP_MFLO);
        chk("mulu_hi", hi, 32'hFFFF_FFFE);
        chk("mulu_lo_abs", lo, 32'h0000_0001);
`ifdef MDU_PERF_CNT_EN
        chk("perf_case3", perf_stall_cnt, 32'd6);
`endif
        mt(OP_MTHI, 32'h1234_5678);
        mt(OP_MTLO, 32'hCAFE_F00D);
        mf(OP_MFHI);
        muldiv(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_lo_abs", lo, 32'h8000_0000);

        // Undefined opcodes behave as NONE
        for (int k = 9; k < 16; k++) begin
            e_valid = 1'b1; e_op = 4'(k); d_is_mdu = 1'b1;
            #1;
            chk("badop_start", 32'(start), 32'd0);
            chk("badop_rd", e_mdu_rd, 32'd0);
            next_cyc();
            chk("badop_busy", 32'(busy), 32'd0);
        end
        e_valid = 1'b0; e_op = 4'd0; d_is_mdu = 1'b0;

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            if (sel < 4)
                muldiv(4'(sel + 1), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
            else if (sel < 6)
                mt(4'(sel + 1), $urandom);
            else
                mf(4'(sel + 1));
        end

`ifdef MDU_PERF_CNT_EN
        chk("perf_total", perf_stall_cnt, 32'(m_perf));
`endif

        // Reset on the 3rd busy cycle of a DIV abandons the result
        e_valid = 1'b1; e_op = OP_DIV; e_rs = 32'd100; e_rt = 32'd7; d_is_mdu = 1'b0;
        #1;
        chk("rstdiv_start", 32'(start), 32'd1);
        next_cyc();
        e_valid = 1'b0; e_op = 4'd0;
        next_cyc();
        next_cyc();
        chk("rstdiv_busy3", 32'(busy), 32'd1);
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0; m_perf = 0;
        chk("rstdiv_busy", 32'(busy), 32'd0);
        chk("rstdiv_hi", hi, 32'd0);
        chk("rstdiv_lo", lo, 32'd0);
        for (int i = 0; i < DC + 2; i++) next_cyc();
        chk("rstdiv_no_commit_hi", hi, 32'd0);
        chk("rstdiv_no_commit_lo", lo, 32'd0);
        $display("reset during div -> hi=%08h lo=%08h", hi, lo);

        // Start coinciding with reset: reset wins
        reset = 1'b1; e_valid = 1'b1; e_op = OP_MULT; e_rs = 32'd5; e_rt = 32'd5; d_is_mdu = 1'b1;
        #1;
        chk("rststart_start", 32'(start), 32'd0);
        chk("rststart_stall", 32'(stall_req), 32'd0);
        next_cyc();
        reset = 1'b0; e_valid = 1'b0; e_op = 4'd0; d_is_mdu = 1'b0;
        #1;
        chk("rststart_busy", 32'(busy), 32'd0);
`ifdef MDU_PERF_CNT_EN
        chk("perf_after_reset", perf_stall_cnt, 32'd0);
`endif
        $display("start with reset -> busy=%0d", busy);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
